// File: rtl/hdlc_tx_framer.sv
// hdlc_tx_framer
//   Transmit-side HDLC framer. Accepts payload bytes over a valid/ready
//   handshake and serialises them LSB first, one bit per clock: opening
//   flag, zero-stuffed payload, closing flag. A requested abort or a
//   payload underrun ends the frame with a run of unstuffed 1s instead.
//   The line idles at mark (1).
//
// Handshake: a byte is transferred on every rising edge where
//   in_valid & in_ready. in_data/in_last must be stable while in_valid is
//   high. in_ready depends only on internal state, never on in_valid.
//
// Ports
//   clk       in   1  clock, all state on rising edge
//   areset    in   1  asynchronous, active-high reset
//   in_data   in   8  payload byte
//   in_valid  in   1  in_data valid
//   in_last   in   1  in_data is the final byte of the frame
//   in_ready  out  1  byte accepted on in_valid & in_ready
//   in_abort  in   1  pulse: abort the frame (honoured in OPEN/DATA only)
//   tx_bit    out  1  serial line bit (registered)
//   tx_en     out  1  high while flag/data/stuff/abort bits are driven
//   tx_stuff  out  1  high when tx_bit is an inserted stuff 0
//   state_dbg out  3  current FSM state (S_IDLE..S_ABORT encoding)
module hdlc_tx_framer #(
  parameter logic [7:0] FLAG      = 8'h7E,
  parameter int         ABORT_LEN = 8
) (
  input  logic       clk,
  input  logic       areset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  input  logic       in_abort,
  output logic       tx_bit,
  output logic       tx_en,
  output logic       tx_stuff,
  output logic [2:0] state_dbg
);

  // The state names what tx_bit carries during the current cycle.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_OPEN  = 3'd1,
    S_DATA  = 3'd2,
    S_CLOSE = 3'd3,
    S_ABORT = 3'd4
  } state_t;

  localparam logic [7:0] ABORT_CNT = 8'(ABORT_LEN);

  state_t     state;
  logic [7:0] cnt;        // flag / abort bits emitted so far, incl. current
  logic [7:0] hold;
  logic       hold_full;
  logic       last_seen;  // final byte of the frame has been accepted
  logic [7:0] shift;      // data bits of the current byte not yet emitted
  logic [3:0] bits_left;
  logic [2:0] ones;       // consecutive data 1s emitted
  logic       accept;
  logic [7:0] src;        // next byte for the shifter: hold, else bypass

  assign in_ready  = ~hold_full & ~last_seen &
                     ((state == S_IDLE) || (state == S_OPEN) || (state == S_DATA));
  assign accept    = in_valid & in_ready;
  assign state_dbg = state;

  always_comb begin
    src = in_data;
    if (hold_full) src = hold;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      last_seen <= 1'b0;
      shift     <= '0;
      bits_left <= '0;
      ones      <= '0;
      tx_bit    <= 1'b1;
      tx_en     <= 1'b0;
      tx_stuff  <= 1'b0;
    end else begin
      // Default: a handshaken byte lands in hold. Branches below override
      // this when the byte is bypassed straight into the shifter or flushed.
      if (accept) begin
        hold      <= in_data;
        hold_full <= 1'b1;
        if (in_last) last_seen <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          tx_bit   <= 1'b1;
          tx_en    <= 1'b0;
          tx_stuff <= 1'b0;
          if (accept) begin
            state  <= S_OPEN;
            tx_bit <= FLAG[0];
            tx_en  <= 1'b1;
            cnt    <= 8'd1;
            ones   <= '0;
          end
        end

        S_OPEN: begin
          if (in_abort) begin
            state     <= S_ABORT;
            tx_bit    <= 1'b1;
            tx_stuff  <= 1'b0;
            cnt       <= 8'd1;
            hold_full <= 1'b0;
            last_seen <= 1'b0;
            ones      <= '0;
            bits_left <= '0;
          end else if (cnt != 8'd8) begin
            tx_bit <= FLAG[cnt[2:0]];
            cnt    <= cnt + 8'd1;
          end else begin
            // hold is always full here: it was filled by the IDLE handshake
            state     <= S_DATA;
            tx_bit    <= hold[0];
            tx_stuff  <= 1'b0;
            shift     <= {1'b0, hold[7:1]};
            bits_left <= 4'd7;
            ones      <= {2'b00, hold[0]};
            hold_full <= 1'b0;
          end
        end

        S_DATA: begin
          if (in_abort) begin
            state     <= S_ABORT;
            tx_bit    <= 1'b1;
            tx_stuff  <= 1'b0;
            cnt       <= 8'd1;
            hold_full <= 1'b0;
            last_seen <= 1'b0;
            ones      <= '0;
            bits_left <= '0;
          end else if (ones == 3'd5) begin
            // stuff bit; shifter paused
            tx_bit   <= 1'b0;
            tx_stuff <= 1'b1;
            ones     <= '0;
          end else if (bits_left != 4'd0) begin
            tx_bit    <= shift[0];
            tx_stuff  <= 1'b0;
            shift     <= {1'b0, shift[7:1]};
            bits_left <= bits_left - 4'd1;
            ones      <= shift[0] ? 3'(ones + 3'd1) : 3'd0;
          end else if (hold_full || accept) begin
            // byte drained: reload from hold or bypass the byte arriving now;
            // the ones run carries across the byte boundary
            tx_bit    <= src[0];
            tx_stuff  <= 1'b0;
            shift     <= {1'b0, src[7:1]};
            bits_left <= 4'd7;
            ones      <= src[0] ? 3'(ones + 3'd1) : 3'd0;
            hold_full <= 1'b0;
          end else if (last_seen) begin
            state    <= S_CLOSE;
            tx_bit   <= FLAG[0];
            tx_stuff <= 1'b0;
            cnt      <= 8'd1;
            ones     <= '0;
          end else begin
            // underrun: nothing to send and the frame was not closed
            state    <= S_ABORT;
            tx_bit   <= 1'b1;
            tx_stuff <= 1'b0;
            cnt      <= 8'd1;
            ones     <= '0;
          end
        end

        S_CLOSE: begin
          if (cnt != 8'd8) begin
            tx_bit <= FLAG[cnt[2:0]];
            cnt    <= cnt + 8'd1;
          end else begin
            state     <= S_IDLE;
            tx_bit    <= 1'b1;
            tx_en     <= 1'b0;
            last_seen <= 1'b0;
          end
        end

        S_ABORT: begin
          if (cnt != ABORT_CNT) begin
            tx_bit <= 1'b1;
            cnt    <= cnt + 8'd1;
          end else begin
            state     <= S_IDLE;
            tx_bit    <= 1'b1;
            tx_en     <= 1'b0;
            last_seen <= 1'b0;
          end
        end

        default: begin
          state  <= S_IDLE;
          tx_bit <= 1'b1;
          tx_en  <= 1'b0;
        end
      endcase
    end
  end

endmodule
